shiftreg_sequencer: RTL
=======================

# shiftreg_sequencer

Command sequencer placed directly upstream of the generic shift register. It accepts one command at a time over a valid/ready handshake: load, shift left N, shift right N, or wait N. It then drives the register's mode, load-value and serial-input pins cycle by cycle, and signals completion with a single `done_o` pulse. This lets software-style controllers issue multi-bit shift operations without counting cycles themselves.

## Interface
- `DATASIZE`, default 8: width of the controlled register and of `cmd_data_i` / `load_value_o`.
- `COUNTWIDTH`, default `$clog2(DATASIZE)+1`: width of `cmd_count_i`.
- `clk_i`, input, 1: the single clock.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `cmd_valid_i`, input, 1: command present.
- `cmd_ready_o`, output, 1: sequencer can accept a command.
- `cmd_op_i`, input, 2: operation code. 00 = wait, 01 = shift left, 10 = shift right, 11 = load.
- `cmd_count_i`, input, COUNTWIDTH: number of cycles for shift and wait. Ignored for load.
- `cmd_data_i`, input, DATASIZE: the load value for load. For shifts, the fill bits, consumed LSB first.
- `mode_o`, output, 2: mode to the shift register, using the same encoding as `cmd_op_i`.
- `load_value_o`, output, DATASIZE: parallel load value.
- `ser_in_lsb_o`, output, 1: serial bit entering at the LSB during shift left.
- `ser_in_msb_o`, output, 1: serial bit entering at the MSB during shift right.
- `busy_o`, output, 1: a command is executing, i.e. the block is in RUN or DONE.
- `done_o`, output, 1: one-cycle completion pulse.

## Operation
- States are IDLE, RUN and DONE. All outputs except `cmd_ready_o` are registered.
- **IDLE**
  - `cmd_ready_o` = 1 and `mode_o` = 00.
  - On `cmd_valid_i` && `cmd_ready_o` the block latches op, data and count into the fill register, and counts as follows:
    - load: cnt = 1.
    - shift or wait: cnt = min(`cmd_count_i`, DATASIZE), i.e. it saturates at DATASIZE.
  - If the effective cnt is 0, the next state is DONE. Otherwise it is RUN.
- **RUN**
  - `mode_o` = latched op.
  - Shift left: `ser_in_lsb_o` = fill[0] and `ser_in_msb_o` = 0.
  - Shift right: `ser_in_msb_o` = fill[0] and `ser_in_lsb_o` = 0.
  - Load: `load_value_o` = latched data. In every other cycle `load_value_o` = 0.
  - Each RUN cycle, fill shifts right by one with a 0 entering at the MSB, and cnt decrements.
  - Leaves for DONE after the cycle in which cnt reaches 1.
- **DONE**
  - Lasts one cycle, with `mode_o` = 00, `done_o` = 1 and `cmd_ready_o` = 0.
  - Next state is IDLE.
- Wait (op 00) drives `mode_o` = 00 for cnt cycles, so the register holds its value.
- `cmd_valid_i` may be held high across commands. Nothing is accepted outside IDLE, and inputs presented then are ignored without corrupting the running command.
- A reset asserted mid-command aborts it:
  - Outputs are driven to their reset values from the next edge.
  - No `done_o` is produced.
  - The register keeps whatever bits were already shifted.

## Timing
- Reset values:
  - `mode_o` = 00.
  - `load_value_o`, `ser_in_lsb_o`, `ser_in_msb_o`, `busy_o` and `done_o` = 0.
  - State = IDLE.
- `cmd_ready_o` = (state == IDLE) && !`rst_i`, so it is 0 while reset is high.
- Command accepted at the edge ending cycle N:
  - RUN occupies cycles N+1 .. N+cnt.
  - DONE is cycle N+cnt+1.
  - IDLE, with `cmd_ready_o` = 1, returns at N+cnt+2.
- A load therefore asserts `mode_o` = 11 in N+1 only, and `done_o` in N+2.
- With cnt = 0, DONE is cycle N+1.
- Throughput is one command per cnt+2 cycles.
- The shift register samples `mode_o` on the edge ending each RUN cycle, so its contents are final at the edge ending the last RUN cycle, coincident with entry into DONE.

## Structure
- Package `shiftreg_pkg` holds:
  - `mode_t` enum: MODE_HOLD = 2'b00, MODE_SHL = 2'b01, MODE_SHR = 2'b10, MODE_LOAD = 2'b11. Shared with the shift register's users.
  - `seq_state_t` enum: IDLE, RUN, DONE.
- No sub-module inside the sequencer.
- The bench instantiates `shiftreg_sequencer` driving `shiftregister`, with `shiftregister` as the checker target.

## Test plan
- **Load:** reset, then op 11 with data 0xA5 accepted in cycle N.
  - `mode_o` = 11 and `load_value_o` = 0xA5 in N+1 only.
  - `done_o` in N+2; the register reads 0xA5.
- **Shift left:** after loading 0x00, send op 01, count 3, data 0b101.
  - `ser_in_lsb_o` = 1, 0, 1 over N+1..N+3.
  - The register ends at 0x05, with `done_o` in N+4.
- **Shift right saturation:** after loading 0xFF, send op 10, count 12, data 0x00.
  - Exactly 8 RUN cycles with `mode_o` = 10.
  - The register ends at 0x00, with `done_o` in N+9.
- **Zero count:** op 01 with count 0.
  - `mode_o` stays 00.
  - `done_o` in N+1 and the register is unchanged.
- **Reset mid-shift:** op 01 with count 6; assert `rst_i` during the 3rd RUN cycle.
  - `mode_o` = 00 and `busy_o` = 0 from the next edge.
  - No `done_o` pulse.
  - `cmd_ready_o` = 1 the cycle after `rst_i` drops.
- **Back-to-back:** `cmd_valid_i` held high with load 0x3C followed by wait count 2.
  - The second command is accepted only in IDLE, at the cycle after `done_o`.
  - `mode_o` = 00 for 2 cycles, then `done_o`; the register still reads 0x3C.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared types for the shift register and its command sequencer.
//   mode_t      : register mode / command opcode encoding
//   seq_state_t : sequencer control states
package shiftreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/shiftregister.sv
// Generic shift register driven by a 2-bit mode.
//   clk_i, rst_i     : clock, synchronous active-high clear
//   mode_i           : hold / shift left / shift right / parallel load
//   load_value_i     : parallel load value
//   ser_in_lsb_i     : bit entering at the LSB on shift left
//   ser_in_msb_i     : bit entering at the MSB on shift right
//   q_o              : register contents
module shiftregister
  import shiftreg_pkg::*;
#(
  parameter int unsigned DATASIZE = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          mode_i,
  input  logic [DATASIZE-1:0] load_value_i,
  input  logic                ser_in_lsb_i,
  input  logic                ser_in_msb_i,
  output logic [DATASIZE-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else begin
      case (mode_t'(mode_i))
        MODE_SHL:  q_o <= {q_o[DATASIZE-2:0], ser_in_lsb_i};
        MODE_SHR:  q_o <= {ser_in_msb_i, q_o[DATASIZE-1:1]};
        MODE_LOAD: q_o <= load_value_i;
        default:   q_o <= q_o;
      endcase
    end
  end

endmodule

// File: rtl/shiftreg_sequencer.sv
// Command sequencer in front of the shift register: accepts one
// load / shift-left-N / shift-right-N / wait-N command at a time and
// drives the register pins cycle by cycle, then pulses done_o.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   cmd_valid_i/ready_o: command handshake (ready only in IDLE, not in reset)
//   cmd_op_i           : 00 wait, 01 shl, 10 shr, 11 load
//   cmd_count_i        : cycle count for shift/wait, saturates at DATASIZE
//   cmd_data_i         : load value, or shift fill bits consumed LSB first
//   mode_o, load_value_o, ser_in_lsb_o, ser_in_msb_o : register controls
//   busy_o             : command in RUN or DONE
//   done_o             : one-cycle completion pulse
module shiftreg_sequencer
  import shiftreg_pkg::*;
#(
  parameter int unsigned DATASIZE   = 8,
  parameter int unsigned COUNTWIDTH = $clog2(DATASIZE) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [COUNTWIDTH-1:0] cmd_count_i,
  input  logic [DATASIZE-1:0]   cmd_data_i,
  output logic [1:0]            mode_o,
  output logic [DATASIZE-1:0]   load_value_o,
  output logic                  ser_in_lsb_o,
  output logic                  ser_in_msb_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [COUNTWIDTH-1:0] CNT_MAX = COUNTWIDTH'(DATASIZE);
  localparam logic [COUNTWIDTH-1:0] CNT_ONE = COUNTWIDTH'(1);

  seq_state_t                state_q, state_d;
  mode_t                     op_q, op_d;
  logic [COUNTWIDTH-1:0]     cnt_q, cnt_d;
  logic [DATASIZE-1:0]       fill_q, fill_d;

  mode_t                     mode_d;
  logic [DATASIZE-1:0]       load_value_d;
  logic                      ser_lsb_d, ser_msb_d, busy_d, done_d;

  assign cmd_ready_o = (state_q == IDLE) && !rst_i;

  // State, operand and registered-output update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= MODE_HOLD;
      cnt_q        <= '0;
      fill_q       <= '0;
      mode_o       <= MODE_HOLD;
      load_value_o <= '0;
      ser_in_lsb_o <= 1'b0;
      ser_in_msb_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      mode_o       <= mode_d;
      load_value_o <= load_value_d;
      ser_in_lsb_o <= ser_lsb_d;
      ser_in_msb_o <= ser_msb_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
    end
  end

  // Next state and next output values; outputs are derived from the
  // upcoming state so each register shows the cycle it belongs to.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          op_d   = mode_t'(cmd_op_i);
          fill_d = cmd_data_i;
          if (mode_t'(cmd_op_i) == MODE_LOAD) begin
            cnt_d = CNT_ONE;
          end else begin
            cnt_d = (cmd_count_i > CNT_MAX) ? CNT_MAX : cmd_count_i;
          end
          state_d = (cnt_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        fill_d = {1'b0, fill_q[DATASIZE-1:1]};
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mode_d       = (state_d == RUN) ? op_d : MODE_HOLD;
    ser_lsb_d    = (state_d == RUN) && (op_d == MODE_SHL) && fill_d[0];
    ser_msb_d    = (state_d == RUN) && (op_d == MODE_SHR) && fill_d[0];
    load_value_d = ((state_d == RUN) && (op_d == MODE_LOAD)) ? fill_d : '0;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

endmodule
